rv_alu_mdu: RTL and testbench
=============================

// Module: rv_alu_mdu
// PURPOSE
//  Parametrised execute unit: full RV base ALU op set plus the RV-M multiply/divide ops.
//  Base ops complete in 1 cycle; MUL*/DIV*/REM* run iteratively (radix-2, one bit per cycle).
//  Sits in EX between the decode/issue register and the writeback register.
//  Uses a valid/ready handshake on both sides so EX can stall the pipe for long ops.
// PARAMETERS
//  XLEN  32            operand/result width (power of 2, >=8)
//  SHW   $clog2(XLEN)  shift-amount width (derived; do not override)
// PORTS
//  clk_i      in   1     clock, all state on rising edge
//  rst_i      in   1     synchronous reset, active-high
//  kill_i     in   1     pipeline flush: abort any op in flight, drop held result
//  valid_i    in   1     operands/op valid
//  ready_o    out  1     unit can accept (idle, or holding a result that is consumed this cycle)
//  op_i       in   5     operation code (see BEHAVIOUR)
//  a_i        in   XLEN  operand A (rs1)
//  b_i        in   XLEN  operand B (rs2/imm)
//  valid_o    out  1     result valid
//  ready_i    in   1     downstream accepts result
//  result_o   out  XLEN  result, stable while valid_o && !ready_i
//  illegal_o  out  1     qualified by valid_o: op_i was unassigned (result_o = 0)
// BEHAVIOUR
//  Op codes: 00000 SUB, 00001 ADD, 00010 SLL, 00011 SLT (signed), 00100 SLTU, 00101 XOR,
//   00110 SRA, 00111 SRL, 01000 OR, 01001 AND; 10000 MUL, 10001 MULH, 10010 MULHSU,
//   10011 MULHU, 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU; all others illegal.
//  Shifts use b_i[SHW-1:0]; add/sub wrap mod 2^XLEN. SLT/SLTU yield 0 or 1.
//  FSM: IDLE -> (accept base/illegal/special-case div) -> DONE
//       IDLE -> (accept MUL*) -> MUL -> DONE; IDLE -> (accept DIV*/REM*) -> DIV -> DONE
//       DONE -> (ready_i) -> IDLE, or straight to next op if valid_i in the same cycle.
//  Accept = valid_i && ready_o; ready_o = (state==IDLE) || (state==DONE && ready_i).
//  Operands and op are registered on accept; a_i/b_i/op_i are don't-care afterwards.
//  Latency (accept at cycle N): base/illegal -> valid_o at N+1; MUL*/DIV* -> N+XLEN+1.
//  MUL: shift-add over XLEN iterations on |a|,|b| with a 2*XLEN product; sign applied at end
//   per op (MULH s*s, MULHSU s*u, MULHU u*u). MUL returns the low half, MULH* the high half.
//  DIV: restoring, XLEN iterations on magnitudes; quotient/remainder sign fixed at end
//   (remainder takes the sign of the dividend).
//  Special cases, resolved at accept with no iteration (valid_o at N+1):
//   b==0: DIV/DIVU -> all ones; REM/REMU -> a.
//   DIV/REM a==-2^(XLEN-1), b==-1 (signed overflow): DIV -> a, REM -> 0.
//  Iteration counter runs XLEN-1 downto 0; leaves MUL/DIV when it hits 0.
//  valid_o=1 only in DONE; result_o/illegal_o held until handshake completes.
//  kill_i (has priority over everything except rst_i): next state IDLE, valid_o=0 next cycle;
//   a valid_i presented in the same cycle as kill_i is not accepted (ready_o forced 0).
//  Reset: state IDLE, valid_o=0, result_o=0, illegal_o=0, ready_o=1 after the reset edge;
//   reset mid-MUL/DIV discards the op, with no output.
// TESTING
//  ADD 0x7FFFFFFF+1 -> 0x80000000 at N+1; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0; SRA 0x80000000>>4 -> 0xF8000000.
//  MULH 0xFFFFFFFF*0xFFFFFFFF -> 0; MULHU same -> 0xFFFFFFFE; MUL 7*-3 -> 0xFFFFFFEB; valid_o at N+33.
//  DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2 (33 cycles).
//  DIV x/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000; each valid_o at N+1.
//  Backpressure: ready_i=0 for 5 cycles in DONE -> result_o stable, ready_o=0; ready_i=1 plus valid_i -> back-to-back accept.
//  kill_i at iteration 10 of DIV -> no valid_o; next ADD accepted after kill -> valid_o 1 cycle later; illegal op 11111 -> illegal_o=1, result 0.

Source files
------------

// File: rtl/rv_alu_mdu_if.sv
// Issue/writeback handshake bundle for the EX-stage ALU/MDU.
// Latency: none (wires only).
// Backpressure: valid/ready on both sides; kill_i flushes whatever is in flight.
interface rv_alu_mdu_if #(
  parameter int XLEN = 32
);
  logic            kill_i;
  logic            valid_i;
  logic            ready_o;
  logic [4:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;
  logic            illegal_o;

  // pipeline side: issues ops and consumes results
  modport master (
    output kill_i, valid_i, op_i, a_i, b_i, ready_i,
    input  ready_o, valid_o, result_o, illegal_o
  );

  // execute unit side
  modport slave (
    input  kill_i, valid_i, op_i, a_i, b_i, ready_i,
    output ready_o, valid_o, result_o, illegal_o
  );
endinterface

// File: rtl/rv_alu_mdu.sv
// RV base ALU plus RV-M multiply/divide execute unit (radix-2 iterative MDU).
// Latency: base/illegal/div-special 1 cycle; MUL*/DIV*/REM* XLEN+1 cycles after accept.
// Backpressure: result held in DONE until ready_i; ready_o low while iterating or held.
module rv_alu_mdu #(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  rv_alu_mdu_if.slave  bus
);

  localparam logic [4:0] OP_SUB  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SLL  = 5'b00010;
  localparam logic [4:0] OP_SLT  = 5'b00011;
  localparam logic [4:0] OP_SLTU = 5'b00100;
  localparam logic [4:0] OP_XOR  = 5'b00101;
  localparam logic [4:0] OP_SRA  = 5'b00110;
  localparam logic [4:0] OP_SRL  = 5'b00111;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e            state;
  logic [2*XLEN-1:0] acc_q;    // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
  logic [XLEN-1:0]   opnd_q;   // MUL: |multiplicand|; DIV: |divisor|
  logic [SHW-1:0]    cnt_q;
  logic [1:0]        sel_q;    // low op bits pick the result flavour at the end
  logic              neg_q;    // product / quotient sign
  logic              rneg_q;   // remainder sign (follows the dividend)

  logic              accept;
  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   alu_res;
  logic              is_base, is_mul, is_div;
  logic              a_sgn, b_sgn;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   div_spec;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt, mul_fix;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN:0]     div_t;
  logic [2*XLEN-1:0] div_nxt;
  logic [XLEN-1:0]   quot, remd, div_res;

  // a kill cycle never accepts, even if the unit is otherwise free
  assign bus.ready_o = !bus.kill_i &&
                       ((state == S_IDLE) || ((state == S_DONE) && bus.ready_i));
  assign accept = bus.valid_i && bus.ready_o;
  assign shamt  = bus.b_i[SHW-1:0];

  // single-cycle base ops, computed straight from the issue operands
  always_comb begin
    alu_res = '0;
    case (bus.op_i)
      OP_SUB:  alu_res = bus.a_i - bus.b_i;
      OP_ADD:  alu_res = bus.a_i + bus.b_i;
      OP_SLL:  alu_res = bus.a_i << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.a_i) < $signed(bus.b_i))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.a_i < bus.b_i)};
      OP_XOR:  alu_res = bus.a_i ^ bus.b_i;
      OP_SRA:  alu_res = $unsigned($signed(bus.a_i) >>> shamt);
      OP_SRL:  alu_res = bus.a_i >> shamt;
      OP_OR:   alu_res = bus.a_i | bus.b_i;
      OP_AND:  alu_res = bus.a_i & bus.b_i;
      default: alu_res = '0;
    endcase
  end

  // op classification, operand magnitudes and the no-iteration divide cases
  always_comb begin
    is_base  = (bus.op_i[4:3] == 2'b00) || (bus.op_i == OP_OR) || (bus.op_i == OP_AND);
    is_mul   = (bus.op_i[4:2] == 3'b100);
    is_div   = (bus.op_i[4:2] == 3'b101);
    // MUL/MULH/MULHSU treat a as signed, MUL/MULH treat b as signed; DIV/REM have op[0]=0
    a_sgn    = bus.a_i[XLEN-1] && (is_mul ? (bus.op_i[1:0] != 2'b11) : !bus.op_i[0]);
    b_sgn    = bus.b_i[XLEN-1] && (is_mul ? !bus.op_i[1] : !bus.op_i[0]);
    a_mag    = a_sgn ? -bus.a_i : bus.a_i;
    b_mag    = b_sgn ? -bus.b_i : bus.b_i;
    div_zero = (bus.b_i == '0);
    div_ovf  = !bus.op_i[0] && (bus.a_i == INT_MIN) && (bus.b_i == '1);
    if (div_zero) div_spec = bus.op_i[1] ? bus.a_i : '1;
    else          div_spec = bus.op_i[1] ? '0 : bus.a_i;
  end

  // one shift-add / restoring-subtract step, plus the sign fix for the final step
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nxt = {mul_sum, acc_q[XLEN-1:1]};
    mul_fix = neg_q ? -mul_nxt : mul_nxt;
    mul_res = (sel_q == 2'b00) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];

    // remainder stays below the divisor, so XLEN+1 bits hold the trial difference
    div_t   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, opnd_q};
    div_nxt = div_t[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                          : {div_t[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    quot    = div_nxt[XLEN-1:0];
    remd    = div_nxt[2*XLEN-1:XLEN];
    div_res = sel_q[1] ? (rneg_q ? -remd : remd) : (neg_q ? -quot : quot);
  end

  // control FSM with registered result/valid/illegal
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      bus.valid_o   <= 1'b0;
      bus.result_o  <= '0;
      bus.illegal_o <= 1'b0;
      acc_q         <= '0;
      opnd_q        <= '0;
      cnt_q         <= '0;
      sel_q         <= '0;
      neg_q         <= 1'b0;
      rneg_q        <= 1'b0;
    end else if (bus.kill_i) begin
      state       <= S_IDLE;
      bus.valid_o <= 1'b0;
    end else if (accept) begin
      sel_q         <= bus.op_i[1:0];
      bus.illegal_o <= 1'b0;
      if (is_base) begin
        bus.result_o <= alu_res;
        bus.valid_o  <= 1'b1;
        state        <= S_DONE;
      end else if (is_mul) begin
        acc_q       <= {{XLEN{1'b0}}, b_mag};
        opnd_q      <= a_mag;
        neg_q       <= a_sgn ^ b_sgn;
        cnt_q       <= SHW'(XLEN-1);
        bus.valid_o <= 1'b0;
        state       <= S_MUL;
      end else if (is_div && (div_zero || div_ovf)) begin
        bus.result_o <= div_spec;
        bus.valid_o  <= 1'b1;
        state        <= S_DONE;
      end else if (is_div) begin
        acc_q       <= {{XLEN{1'b0}}, a_mag};
        opnd_q      <= b_mag;
        neg_q       <= a_sgn ^ b_sgn;
        rneg_q      <= a_sgn;
        cnt_q       <= SHW'(XLEN-1);
        bus.valid_o <= 1'b0;
        state       <= S_DIV;
      end else begin
        bus.result_o  <= '0;
        bus.illegal_o <= 1'b1;
        bus.valid_o   <= 1'b1;
        state         <= S_DONE;
      end
    end else begin
      case (state)
        S_MUL: begin
          acc_q <= mul_nxt;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            bus.result_o <= mul_res;
            bus.valid_o  <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DIV: begin
          acc_q <= div_nxt;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            bus.result_o <= div_res;
            bus.valid_o  <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.ready_i) begin
            bus.valid_o <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_alu_mdu.sv
// Randomized + directed bench for rv_alu_mdu against an arithmetic reference model.
// Latency: checks result, illegal flag and cycles from accept to valid_o.
// Backpressure: exercises ready_i stalls, back-to-back accept, kill and reset mid-op.
module tb_rv_alu_mdu;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  rv_alu_mdu_if #(.XLEN(32)) bus ();

  rv_alu_mdu #(.XLEN(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference: RISC-V semantics from plain 64-bit / signed arithmetic
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic ill, output int lat);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] sa, sb;
    sa  = a;
    sb  = b;
    res = '0;
    ill = 1'b0;
    lat = 1;
    case (op)
      5'd0:  res = a - b;
      5'd1:  res = a + b;
      5'd2:  res = a << b[4:0];
      5'd3:  res = (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  res = (a < b) ? 32'd1 : 32'd0;
      5'd5:  res = a ^ b;
      5'd6:  res = sa >>> b[4:0];
      5'd7:  res = a >> b[4:0];
      5'd8:  res = a | b;
      5'd9:  res = a & b;
      5'd16: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); res = sp[31:0];  lat = 33; end
      5'd17: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); res = sp[63:32]; lat = 33; end
      5'd18: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});       res = sp[63:32]; lat = 33; end
      5'd19: begin up = {32'b0, a} * {32'b0, b};                               res = up[63:32]; lat = 33; end
      5'd20: begin
        if (b == 0)                                 res = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == '1)      res = a;
        else begin res = sa / sb; lat = 33; end
      end
      5'd21: begin
        if (b == 0) res = 32'hFFFFFFFF;
        else begin res = a / b; lat = 33; end
      end
      5'd22: begin
        if (b == 0)                                 res = a;
        else if (a == 32'h80000000 && b == '1)      res = 32'd0;
        else begin res = sa % sb; lat = 33; end
      end
      5'd23: begin
        if (b == 0) res = a;
        else begin res = a % b; lat = 33; end
      end
      default: ill = 1'b1;
    endcase
  endfunction

  // issue one op from IDLE, check latency/result, optionally stall, then consume it
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
    logic [31:0] er;
    logic        ei;
    int          el;
    int          lat;
    logic [31:0] held;
    model(op, a, b, er, ei, el);
    bus.valid_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    #1;
    check("ready_o idle", bus.ready_o, 1);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.op_i    = 5'($urandom);
    bus.a_i     = $urandom;
    bus.b_i     = $urandom;
    lat = 1;
    while (!bus.valid_o && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency op=%0d", op), lat, el);
    check($sformatf("result op=%0d a=%h b=%h", op, a, b), bus.result_o, er);
    check($sformatf("illegal op=%0d", op), bus.illegal_o, ei);
    held = bus.result_o;
    for (int i = 0; i < stall; i++) begin
      check("ready_o stalled", bus.ready_o, 0);
      @(posedge clk); #1;
      check("valid_o held", bus.valid_o, 1);
      check("result held", bus.result_o, held);
    end
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
    check("valid_o drop", bus.valid_o, 0);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] rnd_op();
    int r;
    r = $urandom_range(0, 19);
    if (r < 10)       return 5'(r);
    else if (r < 18)  return 5'(16 + r - 10);
    else if (r == 18) return 5'($urandom_range(10, 15));
    else              return 5'($urandom_range(24, 31));
  endfunction

  initial begin
    int seen;
    n_vec = 0;
    n_err = 0;
    rst         = 1'b1;
    bus.kill_i  = 1'b0;
    bus.valid_i = 1'b0;
    bus.op_i    = '0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset valid_o", bus.valid_o, 0);
    check("reset result_o", bus.result_o, 0);
    check("reset illegal_o", bus.illegal_o, 0);
    check("reset ready_o", bus.ready_o, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed corner cases
    run_op(5'd1,  32'h7FFFFFFF, 32'd1, 0);
    run_op(5'd3,  32'hFFFFFFFF, 32'd1, 0);
    run_op(5'd4,  32'hFFFFFFFF, 32'd1, 0);
    run_op(5'd6,  32'h80000000, 32'd4, 0);
    run_op(5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(5'd16, 32'd7, 32'hFFFFFFFD, 0);
    run_op(5'd20, 32'hFFFFFFF9, 32'd2, 0);
    run_op(5'd22, 32'hFFFFFFF9, 32'd2, 0);
    run_op(5'd21, 32'd100, 32'd7, 0);
    run_op(5'd23, 32'd100, 32'd7, 0);
    run_op(5'd20, 32'd1234, 32'd0, 0);
    run_op(5'd22, 32'd5, 32'd0, 0);
    run_op(5'd20, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(5'd22, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(5'd31, 32'd3, 32'd4, 0);
    run_op(5'd1,  32'd10, 32'd20, 5);
    run_op(5'd18, 32'h80000000, 32'hFFFFFFFF, 3);

    // back-to-back: consume a held result and accept the next op in the same cycle
    bus.valid_i = 1'b1; bus.op_i = 5'd1; bus.a_i = 32'd1; bus.b_i = 32'd2;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    check("b2b first valid", bus.valid_o, 1);
    check("b2b first result", bus.result_o, 3);
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1; bus.op_i = 5'd5; bus.a_i = 32'hF0F0F0F0; bus.b_i = 32'h0FF00FF0;
    #1;
    check("b2b ready_o", bus.ready_o, 1);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    check("b2b second valid", bus.valid_o, 1);
    check("b2b second result", bus.result_o, 32'hFF00FF00);
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
    check("b2b drain", bus.valid_o, 0);

    // kill during the 10th divide iteration; a same-cycle valid_i must be refused
    bus.valid_i = 1'b1; bus.op_i = 5'd21; bus.a_i = 32'd100; bus.b_i = 32'd7;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.kill_i  = 1'b1;
    bus.valid_i = 1'b1; bus.op_i = 5'd1; bus.a_i = 32'd1; bus.b_i = 32'd1;
    #1;
    check("kill ready_o", bus.ready_o, 0);
    @(posedge clk); #1;
    bus.kill_i  = 1'b0;
    bus.valid_i = 1'b0;
    seen = 0;
    repeat (40) begin
      if (bus.valid_o) seen = 1;
      @(posedge clk); #1;
    end
    check("kill no valid_o", seen, 0);
    run_op(5'd1, 32'd5, 32'd6, 0);

    // reset in the middle of a multiply discards it
    bus.valid_i = 1'b1; bus.op_i = 5'd16; bus.a_i = 32'd9; bus.b_i = 32'd9;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset valid_o", bus.valid_o, 0);
    check("midreset result_o", bus.result_o, 0);
    check("midreset ready_o", bus.ready_o, 1);
    seen = 0;
    repeat (40) begin
      if (bus.valid_o) seen = 1;
      @(posedge clk); #1;
    end
    check("midreset no valid_o", seen, 0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      run_op(rnd_op(), rnd_opnd(), rnd_opnd(), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
